// File: rtl/vitdec_pkg.sv
// Shared types and defaults for the Viterbi survivor-memory controller.
// Holds the trellis geometry, the FSM encoding and the memory depth check.
package vitdec_pkg;

    localparam int SSIZE_D = 6;
    localparam int DSIZE_D = 2 ** SSIZE_D;
    localparam int ASIZE_D = 7;
    localparam int TBLEN_D = 32;
    localparam int BLK_D   = 32;

    typedef enum logic {
        IDLE,
        TRACE
    } tb_state_t;

    // Memory must hold two full traceback windows so writes never overtake reads.
    function automatic bit depth_ok(input int asize, input int tblen,
                                    input int blk, input int ssize);
        return ((1 << asize) >= 2 * (tblen + blk)) && (blk >= 1) && (tblen >= ssize);
    endfunction

endpackage

// File: rtl/vitdec_tb_step.sv
// Traceback state register: loads the best state, then follows survivor bits.
// Each enabled step shifts in the decision bit selected by the current state.
module vitdec_tb_step
    import vitdec_pkg::*;
#(
    parameter int SSIZE = SSIZE_D,
    parameter int DSIZE = DSIZE_D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [SSIZE-1:0] best,
    input  logic [DSIZE-1:0] rdata,
    output logic [SSIZE-1:0] state
);

    logic dbit;

    assign dbit = rdata[state];

    // Load on trigger, otherwise step back one trellis stage per enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= best;
        end else if (en) begin
            state <= {state[SSIZE-2:0], dbit};
        end
    end

endmodule

// File: rtl/vitdec_tb_ctrl.sv
// Survivor-memory controller: circular write of decision vectors and
// periodic block traceback emitting decoded bits newest-first.
module vitdec_tb_ctrl
    import vitdec_pkg::*;
#(
    parameter int SSIZE = SSIZE_D,
    parameter int DSIZE = DSIZE_D,
    parameter int ASIZE = ASIZE_D,
    parameter int TBLEN = TBLEN_D,
    parameter int BLK   = BLK_D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_dec,
    input  logic [SSIZE-1:0] in_best,
    output logic             ram_wen,
    output logic [ASIZE-1:0] ram_waddr,
    output logic [DSIZE-1:0] ram_wdata,
    output logic [ASIZE-1:0] ram_raddr,
    input  logic [DSIZE-1:0] ram_rdata,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int SPAN = TBLEN + BLK;
    localparam int FW   = $clog2(SPAN + 1);
    localparam int BW   = $clog2(BLK + 1);
    localparam int CW   = $clog2(SPAN + 1);

    localparam logic [FW-1:0] FILL_TRIG = FW'(SPAN - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(SPAN);
    localparam logic [BW-1:0] BLK_LAST  = BW'(BLK - 1);
    localparam logic [CW-1:0] CNT_OUT   = CW'(TBLEN + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SPAN);

    if (!depth_ok(ASIZE, TBLEN, BLK, SSIZE)) begin : g_cfg_err
        $fatal(1, "vitdec_tb_ctrl: need DEPTH >= 2*(TBLEN+BLK), BLK >= 1, TBLEN >= SSIZE");
    end

    tb_state_t        state_q;
    tb_state_t        state_d;
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] newest;
    logic [FW-1:0]    fill;
    logic [BW-1:0]    bcnt;
    logic [CW-1:0]    cnt;
    logic [SSIZE-1:0] st;
    logic             trig_cond;
    logic             accept;
    logic             trig;
    logic             step_en;

    assign trig_cond = (fill >= FILL_TRIG) && (bcnt == BLK_LAST);
    assign busy      = (state_q == TRACE);
    assign in_ready  = !(busy && trig_cond);
    assign accept    = in_valid && in_ready;
    assign trig      = accept && trig_cond;

    assign ram_wen   = accept;
    assign ram_waddr = wptr;
    assign ram_wdata = in_dec;

    // cnt = k-1 in cycle t(k); read k-1 steps behind the newest vector.
    assign ram_raddr = busy ? (newest - ASIZE'(cnt)) : '0;
    assign step_en   = busy && (cnt != '0);
    assign out_valid = busy && (cnt >= CNT_OUT);
    assign out_last  = busy && (cnt == CNT_LAST);
    assign out_bit   = out_valid && st[SSIZE-1];

    // Write pointer, saturating fill level and block phase advance per accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            fill <= '0;
            bcnt <= '0;
        end else if (accept) begin
            wptr <= wptr + ASIZE'(1);
            if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
            bcnt <= (bcnt == BLK_LAST) ? '0 : bcnt + BW'(1);
        end
    end

    // FSM state, traceback step counter and latched start address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            newest  <= '0;
        end else begin
            state_q <= state_d;
            if (trig) begin
                newest <= wptr;
            end
            cnt <= (busy && state_d == TRACE) ? cnt + CW'(1) : '0;
        end
    end

    // Next state: start on trigger, stop after the oldest bit of the block.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (trig) state_d = TRACE;
            TRACE: if (cnt == CNT_LAST) state_d = IDLE;
        endcase
    end

    vitdec_tb_step #(
        .SSIZE(SSIZE),
        .DSIZE(DSIZE)
    ) u_step (
        .clock(clock),
        .reset(reset),
        .load (trig),
        .en   (step_en),
        .best (in_best),
        .rdata(ram_rdata),
        .state(st)
    );

endmodule

// File: doc/vitdec_tb_ctrl.md
Name: vitdec_tb_ctrl

Overview:
Survivor-memory controller for the Viterbi decoder. It stores one decision vector per trellis step in an external ram_dp instance, used as a circular buffer. Every BLK steps it runs a block traceback of TBLEN+BLK steps through that memory and emits BLK decoded bits, oldest-last (reverse order). The block sits between the ACS array (decision vectors, best state) and the bit-reversal/output stage.

Parameters:
SSIZE, 6, trellis state width (K-1); number of states is 2**SSIZE
DSIZE, 2**SSIZE, decision vector width, one bit per state
ASIZE, 7, survivor memory address width; DEPTH = 2**ASIZE
TBLEN, 32, traceback convergence length (steps read, no output)
BLK, 32, decoded bits per traceback block

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  decision vector valid
in_ready  out  1  controller accepts in_dec this cycle
in_dec  in  DSIZE  decision vector; bit s = survivor bit of state s
in_best  in  SSIZE  best-metric state at this step; used only on trigger steps
ram_wen  out  1  survivor memory write enable
ram_waddr  out  ASIZE  survivor memory write address
ram_wdata  out  DSIZE  survivor memory write data (= in_dec)
ram_raddr  out  ASIZE  survivor memory read address
ram_rdata  in  DSIZE  survivor memory read data, one-cycle registered latency
out_valid  out  1  decoded bit valid
out_bit  out  1  decoded bit
out_last  out  1  last (oldest) bit of the block
busy  out  1  traceback in progress

Behaviour:
- Reset (async, mid-operation included): wptr=0, fill count=0, block count=0, FSM=IDLE. Outputs: in_ready=1, ram_wen=0, ram_waddr=0, ram_raddr=0, out_valid=0, out_bit=0, out_last=0, busy=0. RAM contents are not cleared. Any traceback in flight is aborted with no further output.
- Accept: in_valid & in_ready. ram_wen=accept, ram_waddr=wptr, ram_wdata=in_dec, all combinational. wptr increments mod DEPTH on accept.
- Fill count saturates at TBLEN+BLK. Block count runs 0..BLK-1 and wraps.
- Trigger: an accept with fill reaching/at TBLEN+BLK and block count = BLK-1. First trigger is the (TBLEN+BLK)th accept, then every BLK accepts. On the trigger accept, newest=wptr (address just written) and best=in_best are latched.
- in_ready = !(busy & trigger condition) — a triggering vector stalls until traceback ends; non-triggering vectors are accepted during traceback.
- FSM IDLE -> TRACE on trigger. Cycle t0 = trigger. Reads issue on t1..t(TBLEN+BLK): step i has ram_raddr = newest - i mod DEPTH. The address sequence is independent of data, so one read is issued per cycle.
- Step i data arrives one cycle after its read. State recursion: st0=best; st(i+1) = {st(i)[SSIZE-2:0], rdata_i[st(i)]}. The update is combinational from ram_rdata into the state register.
- For i >= TBLEN: out_valid=1, out_bit=st(i)[SSIZE-1]. out_last=1 at i=TBLEN+BLK-1. First bit at t(TBLEN+2), last at t(TBLEN+BLK+1).
- busy=1 from t1 through t(TBLEN+BLK+1), then the FSM returns to IDLE. A stalled trigger can be accepted in the cycle busy falls (t(TBLEN+BLK+2)), giving back-to-back blocks.
- Out_* has no backpressure; the downstream stage must sink 1 bit/cycle.
- Elaboration check: DEPTH >= 2*(TBLEN+BLK), and BLK >= 1, TBLEN >= SSIZE. Violation is a fatal error. This depth guarantees the write pointer never overtakes an unread traceback address.
- All arithmetic is unsigned. Address arithmetic wraps mod DEPTH.

Decomposition:
- Package vitdec_pkg: SSIZE/DSIZE/ASIZE defaults, TBLEN/BLK defaults, FSM state enum (IDLE, TRACE), and a depth-check constant function.
- One natural sub-module, vitdec_tb_step: state register plus decision-bit mux and shift (inputs: load, best, rdata, en; output: state). Counters and FSM stay in vitdec_tb_ctrl.

Test Plan:
- All-zero in_dec, in_best=0, in_valid constant, 64 accepts -> trigger on 64th accept; ram_raddr runs 63,62,...,0; 32 out_valid bits all 0, starting exactly 34 cycles after trigger; out_last on the 32nd.
- All-ones in_dec, in_best=0 -> state goes 0,1,3,...,63; all 32 output bits = 1.
- Write marker vectors (step n = one-hot at state pattern forcing a known path), best=5 -> output bits match a golden model of the recursion, in reverse order.
- Continuous in_valid for 200 steps -> triggers at accepts 64, 96, 128,...; in_ready low while busy & count=BLK-1; no write to an address still pending read (scoreboard); every block outputs exactly 32 bits.
- Reset asserted at t(TBLEN+5) of a traceback -> next cycle out_valid=0, busy=0, in_ready=1, ram_raddr=0. The next trigger requires a fresh 64 accepts.
- in_valid toggling 1/0 randomly -> trigger count is based on accepts only; output matches the golden model.
